// File: rtl/seq_ser_pkg.sv
// Shared definitions for the serial pattern transmitter.
//   seq_ser_state_t  : transmitter FSM state (IDLE waits for a request,
//                      SEND presents one bit per cycle on the output side)
//   SEQ_SER_MAX_LEN  : default maximum pattern length in bits
//   SEQ_SER_REP_W    : default width of the repeat-count field
package seq_ser_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } seq_ser_state_t;

    localparam int SEQ_SER_MAX_LEN = 8;
    localparam int SEQ_SER_REP_W   = 4;

endpackage

// File: rtl/serialize_sequence_using_shift_reg.sv
// Serial bit-pattern transmitter.
// Accepts a right-aligned pattern word of in_len bits over a valid/ready
// handshake and shifts it out MSB-first (in_pattern[len-1] first), one bit
// per accepted output beat, sending it in_repeat+1 times back to back.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. The producer holds valid and its data stable until the
// transfer; ready may depend combinationally on the opposite side's ready,
// never on the same side's valid.
//
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_valid    : pattern request valid
//   in_ready    : request can be accepted this cycle (comb)
//   in_pattern  : pattern, right-aligned in [in_len-1:0]
//   in_len      : pattern length; 0 is discarded, >MAX_LEN is clamped
//   in_repeat   : extra repetitions (0 = send once)
//   out_valid   : out_bit valid (registered)
//   out_ready   : downstream consumes out_bit this cycle
//   out_bit     : serial data (registered, 0 when out_valid is 0)
//   out_last    : final bit of the final repetition (comb)
//   busy        : a request is in progress (registered)
module serialize_sequence_using_shift_reg
    import seq_ser_pkg::*;
#(
    parameter int MAX_LEN = SEQ_SER_MAX_LEN,
    parameter int LEN_W   = $clog2(MAX_LEN) + 1,
    parameter int REP_W   = SEQ_SER_REP_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MAX_LEN-1:0] in_pattern,
    input  logic [LEN_W-1:0]   in_len,
    input  logic [REP_W-1:0]   in_repeat,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_bit,
    output logic               out_last,
    output logic               busy
);

    localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);

    seq_ser_state_t     state;
    logic [MAX_LEN-1:0] shreg;      // left-aligned: MSB is the bit on the wire
    logic [MAX_LEN-1:0] pat_copy;   // left-aligned copy used for repeats
    logic [LEN_W-1:0]   len_copy;
    logic [LEN_W-1:0]   bit_cnt;    // bits left in the current repetition
    logic [REP_W-1:0]   rep_cnt;    // repetitions left after the current one

    logic [LEN_W-1:0]   len_eff;
    logic [MAX_LEN-1:0] pat_aligned;
    logic               accept;
    logic               beat;

    // Clamp the requested length, then left-align the pattern so the first
    // bit to send always sits in the MSB; the bits above len fall off the top.
    assign len_eff     = (in_len > MAX_LEN_C) ? MAX_LEN_C : in_len;
    assign pat_aligned = in_pattern << (MAX_LEN_C - len_eff);

    assign out_valid = (state == SEND);
    assign busy      = (state == SEND);
    // shreg is cleared whenever SEND is left, so its MSB is 0 in IDLE.
    assign out_bit   = shreg[MAX_LEN-1];
    assign out_last  = (state == SEND) && (bit_cnt == LEN_W'(1)) && (rep_cnt == '0);
    assign in_ready  = (state == IDLE) || (out_last && out_ready);

    assign accept = in_valid && in_ready;
    assign beat   = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            pat_copy <= '0;
            len_copy <= '0;
            bit_cnt  <= '0;
            rep_cnt  <= '0;
        end else if (accept) begin
            // Accepting either from IDLE or on the final beat of the
            // current stream; the new request replaces everything.
            if (len_eff != '0) begin
                state    <= SEND;
                shreg    <= pat_aligned;
                pat_copy <= pat_aligned;
                len_copy <= len_eff;
                bit_cnt  <= len_eff;
                rep_cnt  <= in_repeat;
            end else begin
                // Zero-length request: swallowed, nothing to send.
                state    <= IDLE;
                shreg    <= '0;
                bit_cnt  <= '0;
                rep_cnt  <= '0;
            end
        end else if (beat) begin
            if (bit_cnt == LEN_W'(1)) begin
                if (rep_cnt != '0) begin
                    // End of one repetition: restart from the copy, no gap.
                    shreg   <= pat_copy;
                    bit_cnt <= len_copy;
                    rep_cnt <= rep_cnt - REP_W'(1);
                end else begin
                    state   <= IDLE;
                    shreg   <= '0;
                    bit_cnt <= '0;
                end
            end else begin
                shreg   <= shreg << 1;
                bit_cnt <= bit_cnt - LEN_W'(1);
            end
        end
    end

endmodule
